btn_debounce_multi: RTL and testbench
=====================================

# btn_debounce_multi

Multi-channel, parametrised button front end: synchronises and debounces N_BTN raw buttons and classifies each press as short, long or auto-repeat. It sits between board KEY pins and UI logic such as LED toggles and OLED menu navigation, and replaces the single-channel synchroniser/debouncer. Channels are independent and share one millisecond time base.

## Interface
- CLK_HZ, 50_000_000, clock frequency; ms tick period = CLK_HZ/1000 clocks (must divide exactly)
- N_BTN, 4, number of button channels (1..16)
- DEBOUNCE_MS, 5, stable time required before level changes (>=1)
- LONG_MS, 800, hold time after debounced press before long_press (> DEBOUNCE_MS)
- REPEAT_MS, 200, auto-repeat period after long_press; 0 disables repeat
- ACTIVE_LOW, 1, 1: raw pin low = pressed; 0: raw pin high = pressed
- clk  in  1  system clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- btn_raw  in  N_BTN  asynchronous, noisy button pins
- level  out  N_BTN  debounced pressed state (1 = pressed)
- rise  out  N_BTN  1-cycle pulse when level goes 0→1
- fall  out  N_BTN  1-cycle pulse when level goes 1→0
- short_press  out  N_BTN  1-cycle pulse on release if long_press did not fire
- long_press  out  N_BTN  1-cycle pulse when hold reaches LONG_MS
- repeat_evt  out  N_BTN  1-cycle pulse every REPEAT_MS after long_press while held

## Operation
- Polarity: raw inverted when ACTIVE_LOW=1; everything downstream is active-high "pressed".
- Sync: 2-FF synchroniser per channel; reset value 0 (not pressed).
- Tick: shared prescaler emits a 1-cycle ms_tick every CLK_HZ/1000 clocks; counter reset to 0.
- Debounce per channel: when sync == level, the debounce counter clears immediately. When sync != level, the counter increments on each ms_tick. On the ms_tick where the counter equals DEBOUNCE_MS-1, level <= sync, the counter clears, and rise/fall asserts at that same edge.
- Press FSM per channel (states IDLE, PRESSED, HELD):
  - IDLE: on rise → PRESSED, hold counter = 0.
  - PRESSED: hold counter increments per ms_tick. On the tick where it equals LONG_MS-1, long_press pulses, repeat counter = 0, → HELD. On fall → IDLE with short_press in the same cycle as fall.
  - HELD: if REPEAT_MS>0, the repeat counter increments per ms_tick; at REPEAT_MS-1, repeat_evt pulses and the counter wraps to 0. On fall → IDLE, no short_press.
- Counter widths: $clog2(max value + 1). Counters never exceed terminal values; wrap only as stated.
- Channels never interact. Simultaneous events on several channels produce pulses in the same cycle.
- Reset mid-operation: all state, counters and outputs return to 0 on the next edge. A button still held after reset is re-debounced from scratch and produces a fresh rise.

## Timing
- Reset values: all outputs 0, all FSMs IDLE.
- All outputs registered. Pulses are exactly 1 clk wide. rise/fall coincide with the level edge.
- Press latency from raw edge: 2 clk sync + (DEBOUNCE_MS-1 .. DEBOUNCE_MS) ms, depending on tick phase.
- long_press occurs (LONG_MS-1 .. LONG_MS) ms after rise. Successive repeat_evt pulses are exactly REPEAT_MS*CLK_HZ/1000 clk apart.
- A press shorter than the debounce window produces no output activity.

## Structure
- Package btn_pkg holds the press_state_t enum (IDLE, PRESSED, HELD) and the localparam TICK_DIV function.
- Sub-module btn_channel contains the sync, debounce and FSM logic for one button. It is instantiated N_BTN times via generate; the top level holds only the shared ms prescaler.

## Test plan
Bench parameters: CLK_HZ=10_000 (tick every 10 clk), N_BTN=4, DEBOUNCE_MS=5, LONG_MS=50, REPEAT_MS=20, ACTIVE_LOW=0.
- Glitch: ch0 high 30 clk then low → level stays 0; no pulses on any output.
- Short press: ch1 high 200 clk → rise 42–52 clk after the raw edge; after release, fall and short_press in the same cycle; long_press never fires.
- Long hold: ch2 high 1000 clk → long_press 490–500 clk after rise; repeat_evt at +200 and +400 clk; release → fall only, no short_press.
- Simultaneous: ch0 and ch3 raised on the same edge → identical rise/fall/short_press timing on both channels; ch1/ch2 remain quiet.
- Reset during HELD on ch2: rst high 1 clk → all outputs 0 next cycle; with the button still held, a new rise follows after the debounce window.
- Build with REPEAT_MS=0, hold 1000 clk → exactly one long_press and zero repeat_evt.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and elaboration helpers for the multi-channel button front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } press_state_t;

    // Clocks per millisecond tick; CLK_HZ must be an exact multiple of 1000.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Width needed to hold max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button pins and classified press events for N_BTN channels.
interface btn_debounce_multi_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] short_press;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] repeat_evt;

    modport master (
        output btn_raw,
        input  level, rise, fall, short_press, long_press, repeat_evt
    );

    modport slave (
        input  btn_raw,
        output level, rise, fall, short_press, long_press, repeat_evt
    );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, ms-based debouncer and short/long/repeat classifier.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS = 5,
    parameter int LONG_MS     = 800,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic short_press,
    output logic long_press,
    output logic repeat_evt
);

    localparam int DB_TERM  = DEBOUNCE_MS - 1;
    localparam int HOLD_TERM = LONG_MS - 1;
    localparam int REP_TERM = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
    localparam int DW = cnt_w(DB_TERM);
    localparam int HW = cnt_w(HOLD_TERM);
    localparam int RW = cnt_w(REP_TERM);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] db_cnt;
    logic          flip;
    logic          go_rise;
    logic          go_fall;

    press_state_t  state;
    press_state_t  state_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nx;
    logic          short_nx;
    logic          long_nx;
    logic          repeat_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ACTIVE_LOW ? ~raw : raw;
            sync2 <= sync1;
        end
    end

    // The level flips on the tick that completes DEBOUNCE_MS ticks of disagreement.
    assign flip    = ms_tick && (sync2 != level) && (db_cnt == DW'(DB_TERM));
    assign go_rise = flip && sync2;
    assign go_fall = flip && !sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= go_rise;
            fall <= go_fall;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (ms_tick) begin
                if (flip) begin
                    level  <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            rep_cnt     <= rep_nx;
            short_press <= short_nx;
            long_press  <= long_nx;
            repeat_evt  <= repeat_nx;
        end
    end

    // A release always takes priority over a hold/repeat tick landing on the same edge.
    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        rep_nx    = rep_cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            IDLE: begin
                if (go_rise) begin
                    state_nx = PRESSED;
                    hold_nx  = '0;
                end
            end
            PRESSED: begin
                if (go_fall) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end else if (ms_tick) begin
                    if (hold_cnt == HW'(HOLD_TERM)) begin
                        long_nx  = 1'b1;
                        rep_nx   = '0;
                        state_nx = HELD;
                    end else begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
            end
            HELD: begin
                if (go_fall) begin
                    state_nx = IDLE;
                end else if ((REPEAT_MS > 0) && ms_tick) begin
                    if (rep_cnt == RW'(REP_TERM)) begin
                        repeat_nx = 1'b1;
                        rep_nx    = '0;
                    end else begin
                        rep_nx = rep_cnt + RW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel button front end: one shared millisecond prescaler feeding N_BTN
// independent btn_channel instances.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int N_BTN       = 4,
    parameter int DEBOUNCE_MS = 5,
    parameter int LONG_MS     = 800,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    btn_debounce_multi_if.slave bus
);

    localparam int DIV = tick_div(CLK_HZ);
    localparam int PW  = cnt_w(DIV - 1);

    logic [PW-1:0]    pre_cnt;
    logic             ms_tick;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] short_press;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] repeat_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PW'(DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign ms_tick = (pre_cnt == PW'(DIV - 1));

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .ms_tick     (ms_tick),
            .raw         (bus.btn_raw[i]),
            .level       (level[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .short_press (short_press[i]),
            .long_press  (long_press[i]),
            .repeat_evt  (repeat_evt[i])
        );
    end

    assign bus.level       = level;
    assign bus.rise        = rise;
    assign bus.fall        = fall;
    assign bus.short_press = short_press;
    assign bus.long_press  = long_press;
    assign bus.repeat_evt  = repeat_evt;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios plus random presses, with a
// millisecond-level reference model checked every cycle on two builds (repeat on/off).
module tb_btn_debounce_multi;

    localparam int CLK_HZ = 10_000;
    localparam int NB     = 4;
    localparam int DEB    = 5;
    localparam int LONG   = 50;
    localparam int REP    = 20;
    localparam int DIV    = CLK_HZ / 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] raw = '0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            chk_en = 1'b0;

    btn_debounce_multi_if #(.N_BTN(NB)) bus_a ();
    btn_debounce_multi_if #(.N_BTN(NB)) bus_b ();

    assign bus_a.btn_raw = raw;
    assign bus_b.btn_raw = raw;

    btn_debounce_multi #(
        .CLK_HZ(CLK_HZ), .N_BTN(NB), .DEBOUNCE_MS(DEB), .LONG_MS(LONG),
        .REPEAT_MS(REP), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    btn_debounce_multi #(
        .CLK_HZ(CLK_HZ), .N_BTN(NB), .DEBOUNCE_MS(DEB), .LONG_MS(LONG),
        .REPEAT_MS(0), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic val);
        raw[ch] = val;
    endtask

    // ---------------- reference model (millisecond view of each button) ----------------
    bit       m_h0 [2][NB];
    bit       m_h1 [2][NB];
    bit       m_lvl [2][NB];
    bit       m_act [2][NB];
    bit       m_long [2][NB];
    int       m_diff [2][NB];
    int       m_held [2][NB];
    int       m_phase;
    bit       m_tick;
    bit       m_sync;
    bit       m_flip;
    int       m_rp;
    bit [NB-1:0] e_level [2];
    bit [NB-1:0] e_rise [2];
    bit [NB-1:0] e_fall [2];
    bit [NB-1:0] e_short [2];
    bit [NB-1:0] e_long [2];
    bit [NB-1:0] e_rep [2];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0;
                for (int d = 0; d < 2; d++) begin
                    e_level[d] = '0; e_rise[d] = '0; e_fall[d] = '0;
                    e_short[d] = '0; e_long[d] = '0; e_rep[d] = '0;
                    for (int c = 0; c < NB; c++) begin
                        m_h0[d][c] = 0; m_h1[d][c] = 0; m_lvl[d][c] = 0; m_act[d][c] = 0;
                        m_long[d][c] = 0; m_diff[d][c] = 0; m_held[d][c] = 0;
                    end
                end
            end else begin
                m_tick  = (m_phase == DIV - 1);
                m_phase = (m_phase + 1) % DIV;
                for (int d = 0; d < 2; d++) begin
                    m_rp = (d == 0) ? REP : 0;
                    for (int c = 0; c < NB; c++) begin
                        e_rise[d][c] = 0; e_fall[d][c] = 0; e_short[d][c] = 0;
                        e_long[d][c] = 0; e_rep[d][c] = 0;
                        m_sync = m_h1[d][c];
                        m_h1[d][c] = m_h0[d][c];
                        m_h0[d][c] = raw[c];
                        m_flip = 0;
                        // the level follows the pin once it has disagreed for DEB whole ticks
                        if (m_sync == m_lvl[d][c]) begin
                            m_diff[d][c] = 0;
                        end else if (m_tick) begin
                            m_diff[d][c]++;
                            if (m_diff[d][c] >= DEB) begin
                                m_diff[d][c] = 0;
                                m_lvl[d][c]  = m_sync;
                                m_flip = 1;
                                if (m_sync) begin
                                    e_rise[d][c] = 1; m_act[d][c] = 1;
                                    m_held[d][c] = 0; m_long[d][c] = 0;
                                end else begin
                                    e_fall[d][c]  = 1;
                                    e_short[d][c] = m_act[d][c] && !m_long[d][c];
                                    m_act[d][c]   = 0;
                                end
                            end
                        end
                        if (!m_flip && m_act[d][c] && m_tick) begin
                            m_held[d][c]++;
                            if (m_held[d][c] == LONG) begin
                                e_long[d][c] = 1;
                                m_long[d][c] = 1;
                            end else if (m_long[d][c] && m_rp > 0) begin
                                if ((m_held[d][c] - LONG) % m_rp == 0) e_rep[d][c] = 1;
                            end
                        end
                        e_level[d][c] = m_lvl[d][c];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checkOutput("a.level",       32'(bus_a.level),       32'(e_level[0]));
                checkOutput("a.rise",        32'(bus_a.rise),        32'(e_rise[0]));
                checkOutput("a.fall",        32'(bus_a.fall),        32'(e_fall[0]));
                checkOutput("a.short_press", 32'(bus_a.short_press), 32'(e_short[0]));
                checkOutput("a.long_press",  32'(bus_a.long_press),  32'(e_long[0]));
                checkOutput("a.repeat_evt",  32'(bus_a.repeat_evt),  32'(e_rep[0]));
                checkOutput("b.level",       32'(bus_b.level),       32'(e_level[1]));
                checkOutput("b.rise",        32'(bus_b.rise),        32'(e_rise[1]));
                checkOutput("b.fall",        32'(bus_b.fall),        32'(e_fall[1]));
                checkOutput("b.short_press", 32'(bus_b.short_press), 32'(e_short[1]));
                checkOutput("b.long_press",  32'(bus_b.long_press),  32'(e_long[1]));
                checkOutput("b.repeat_evt",  32'(bus_b.repeat_evt),  32'(e_rep[1]));
            end
        end
    end

    // ---------------- event bookkeeping for the directed timing checks ----------------
    int n_rise [NB];
    int n_fall [NB];
    int n_short [NB];
    int n_long [2][NB];
    int n_rep [2][NB];
    int t_rise [NB];
    int t_fall [NB];
    int t_short [NB];
    int t_long [NB];
    int t_rep2 [$];

    initial begin
        for (int c = 0; c < NB; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_short[c] = 0;
            n_long[0][c] = 0; n_long[1][c] = 0; n_rep[0][c] = 0; n_rep[1][c] = 0;
            t_rise[c] = 0; t_fall[c] = 0; t_short[c] = 0; t_long[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NB; c++) begin
                if (bus_a.rise[c] === 1'b1)        begin n_rise[c]++;  t_rise[c] = cyc;  end
                if (bus_a.fall[c] === 1'b1)        begin n_fall[c]++;  t_fall[c] = cyc;  end
                if (bus_a.short_press[c] === 1'b1) begin n_short[c]++; t_short[c] = cyc; end
                if (bus_a.long_press[c] === 1'b1)  begin n_long[0][c]++; t_long[c] = cyc; end
                if (bus_a.repeat_evt[c] === 1'b1)  begin
                    n_rep[0][c]++;
                    if (c == 2) t_rep2.push_back(cyc);
                end
                if (bus_b.long_press[c] === 1'b1)  n_long[1][c]++;
                if (bus_b.repeat_evt[c] === 1'b1)  n_rep[1][c]++;
            end
        end
    end

    function automatic int totalEvents();
        int s = 0;
        for (int c = 0; c < NB; c++)
            s += n_rise[c] + n_fall[c] + n_short[c] + n_long[0][c] + n_rep[0][c]
                 + n_long[1][c] + n_rep[1][c];
        return s;
    endfunction

    // ---------------- directed and random stimulus ----------------
    int snap_rise [NB];
    int snap_fall [NB];
    int snap_short [NB];
    int snap_long [2][NB];
    int snap_rep [2][NB];
    int set_cyc;
    int lat;
    int snap_total;
    int nrep_before;
    int waited;

    task automatic takeSnapshot();
        for (int c = 0; c < NB; c++) begin
            snap_rise[c] = n_rise[c]; snap_fall[c] = n_fall[c]; snap_short[c] = n_short[c];
            snap_long[0][c] = n_long[0][c]; snap_long[1][c] = n_long[1][c];
            snap_rep[0][c] = n_rep[0][c]; snap_rep[1][c] = n_rep[1][c];
        end
    endtask

    initial begin
        // reset
        rst = 1'b1;
        raw = '0;
        stepCycles(3);
        chk_en = 1'b1;
        checkOutput("reset a.level", 32'(bus_a.level), 0);
        checkOutput("reset a.long_press", 32'(bus_a.long_press), 0);
        checkOutput("reset b.level", 32'(bus_b.level), 0);
        rst = 1'b0;
        stepCycles(20);

        // glitch shorter than the debounce window
        snap_total = totalEvents();
        applyStimulus(0, 1'b1);
        stepCycles(30);
        applyStimulus(0, 1'b0);
        stepCycles(100);
        checkOutput("glitch events", 32'(totalEvents() - snap_total), 0);
        checkOutput("glitch a.level", 32'(bus_a.level), 0);

        // short press on ch1
        takeSnapshot();
        applyStimulus(1, 1'b1);
        set_cyc = cyc;
        stepCycles(200);
        applyStimulus(1, 1'b0);
        stepCycles(100);
        checkOutput("short rise count", 32'(n_rise[1] - snap_rise[1]), 1);
        lat = t_rise[1] - (set_cyc + 1);
        checkOutput($sformatf("short rise latency %0d in 42..52", lat),
                    32'(lat >= 42 && lat <= 52), 1);
        checkOutput("short fall count", 32'(n_fall[1] - snap_fall[1]), 1);
        checkOutput("short_press count", 32'(n_short[1] - snap_short[1]), 1);
        checkOutput("short fall/short_press cycle", 32'(t_short[1]), 32'(t_fall[1]));
        checkOutput("short long count", 32'(n_long[0][1] - snap_long[0][1]), 0);

        // long hold on ch2
        takeSnapshot();
        nrep_before = t_rep2.size();
        applyStimulus(2, 1'b1);
        stepCycles(1000);
        applyStimulus(2, 1'b0);
        stepCycles(100);
        checkOutput("long count", 32'(n_long[0][2] - snap_long[0][2]), 1);
        lat = t_long[2] - t_rise[2];
        checkOutput($sformatf("long latency %0d in 490..500", lat),
                    32'(lat >= 490 && lat <= 500), 1);
        checkOutput("long repeat count", 32'(n_rep[0][2] - snap_rep[0][2]), 2);
        if (t_rep2.size() >= nrep_before + 2) begin
            checkOutput("repeat1 offset", 32'(t_rep2[nrep_before] - t_long[2]), REP * DIV);
            checkOutput("repeat2 offset", 32'(t_rep2[nrep_before + 1] - t_rep2[nrep_before]),
                        REP * DIV);
        end else begin
            checkOutput("repeat pulses recorded", 32'(t_rep2.size() - nrep_before), 2);
        end
        checkOutput("long fall count", 32'(n_fall[2] - snap_fall[2]), 1);
        checkOutput("long short_press count", 32'(n_short[2] - snap_short[2]), 0);
        checkOutput("norepeat long count", 32'(n_long[1][2] - snap_long[1][2]), 1);
        checkOutput("norepeat repeat count", 32'(n_rep[1][2] - snap_rep[1][2]), 0);

        // simultaneous press on ch0 and ch3
        takeSnapshot();
        applyStimulus(0, 1'b1);
        applyStimulus(3, 1'b1);
        stepCycles(150);
        applyStimulus(0, 1'b0);
        applyStimulus(3, 1'b0);
        stepCycles(100);
        checkOutput("simul rise ch0", 32'(n_rise[0] - snap_rise[0]), 1);
        checkOutput("simul rise ch3", 32'(n_rise[3] - snap_rise[3]), 1);
        checkOutput("simul rise cycle", 32'(t_rise[3]), 32'(t_rise[0]));
        checkOutput("simul fall cycle", 32'(t_fall[3]), 32'(t_fall[0]));
        checkOutput("simul short cycle", 32'(t_short[3]), 32'(t_short[0]));
        checkOutput("simul quiet ch1/ch2",
                    32'(n_rise[1] - snap_rise[1] + n_rise[2] - snap_rise[2]), 0);

        // reset while ch2 is in the held state
        takeSnapshot();
        applyStimulus(2, 1'b1);
        stepCycles(700);
        checkOutput("held before reset", 32'(bus_a.level[2]), 1);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("rst a.level", 32'(bus_a.level), 0);
        checkOutput("rst a.rise", 32'(bus_a.rise), 0);
        checkOutput("rst a.fall", 32'(bus_a.fall), 0);
        checkOutput("rst a.short_press", 32'(bus_a.short_press), 0);
        checkOutput("rst a.long_press", 32'(bus_a.long_press), 0);
        checkOutput("rst a.repeat_evt", 32'(bus_a.repeat_evt), 0);
        checkOutput("rst b.level", 32'(bus_b.level), 0);
        rst = 1'b0;
        set_cyc = cyc;
        takeSnapshot();
        waited = 0;
        while (n_rise[2] == snap_rise[2] && waited < 200) begin
            stepCycles(1);
            waited++;
        end
        checkOutput("post-reset rise seen", 32'(n_rise[2] - snap_rise[2]), 1);
        lat = t_rise[2] - (set_cyc + 1);
        checkOutput($sformatf("post-reset rise latency %0d in 42..52", lat),
                    32'(lat >= 42 && lat <= 52), 1);
        applyStimulus(2, 1'b0);
        stepCycles(100);

        // random presses and bounces, checked cycle by cycle against the model
        for (int i = 0; i < 80; i++) begin
            applyStimulus(int'($urandom_range(0, NB - 1)), 1'($urandom));
            if ($urandom_range(0, 5) == 0)
                stepCycles(int'($urandom_range(300, 800)));
            else
                stepCycles(int'($urandom_range(1, 90)));
        end
        raw = '0;
        stepCycles(700);

        chk_en = 1'b0;
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
